// File: rtl/f2i_pkg.sv
// -----------------------------------------------------------------------------
// f2i_pkg
// Shared types and helpers for the float -> fixed-point converter pipeline.
//   - f2i_class_t : operand class decided in the unpack stage
//   - f2i_meta_t  : sign + class, carried unchanged down the pipeline
//   - exp_bias()  : IEEE-style exponent bias for a given exponent width
//   - f_sign/f_exp/f_man : field extraction from a {sign, exp, man} word
//     (the word is zero-extended to 64 bits so one helper serves any format)
//   - classify()  : ZERO / NORM / INF / NAN from the exponent/mantissa flags
// -----------------------------------------------------------------------------
package f2i_pkg;

    typedef enum logic [1:0] {
        F2I_ZERO,
        F2I_NORM,
        F2I_INF,
        F2I_NAN
    } f2i_class_t;

    typedef struct packed {
        logic       sign;
        f2i_class_t cls;
    } f2i_meta_t;

    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic logic f_sign(input logic [63:0] f, input int man_w, input int exp_w);
        return f[man_w + exp_w];
    endfunction

    function automatic logic [63:0] f_exp(input logic [63:0] f, input int man_w, input int exp_w);
        return (f >> man_w) & ((64'd1 << exp_w) - 64'd1);
    endfunction

    function automatic logic [63:0] f_man(input logic [63:0] f, input int man_w);
        return f & ((64'd1 << man_w) - 64'd1);
    endfunction

    // Denormals share the all-zeros exponent with zero and are flushed.
    function automatic f2i_class_t classify(input logic exp_zero, input logic exp_ones,
                                            input logic man_zero);
        if (exp_zero)  return F2I_ZERO;
        if (!exp_ones) return F2I_NORM;
        return man_zero ? F2I_INF : F2I_NAN;
    endfunction

endpackage

// File: rtl/float2int_pipe_if.sv
// -----------------------------------------------------------------------------
// float2int_pipe_if
// Input and output valid/ready streams of the float -> integer converter.
//   in_valid/in_ready/in_float        : float stream into the converter
//   out_valid/out_ready/out_int/
//   out_sat/out_nan                   : integer stream out of the converter
// Modports: master = the surrounding system (drives floats, sinks integers),
//           slave  = the converter.
// -----------------------------------------------------------------------------
interface float2int_pipe_if #(
    parameter int MAN   = 23,
    parameter int EXP   = 8,
    parameter int OUT_W = 24
);
    logic                 in_valid;
    logic                 in_ready;
    logic [MAN+EXP:0]     in_float;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     out_int;
    logic                 out_sat;
    logic                 out_nan;

    modport master (
        output in_valid, in_float, out_ready,
        input  in_ready, out_valid, out_int, out_sat, out_nan
    );

    modport slave (
        input  in_valid, in_float, out_ready,
        output in_ready, out_valid, out_int, out_sat, out_nan
    );
endinterface

// File: rtl/f2i_shift.sv
// -----------------------------------------------------------------------------
// f2i_shift
// Combinational bidirectional barrel shifter for the converter's second stage.
//   mant   in  MAN+1  significand with hidden one
//   shift  in  SH_W   signed shift amount (>=0 left, <0 right)
//   mag    out OUT_W+1 shifted magnitude (one spare bit above the integer range
//                     so -2^(OUT_W-1) stays representable before saturation)
//   guard  out 1      first bit shifted out on a right shift
//   sticky out 1      OR of every bit below guard
//   ovf    out 1      a set bit would land above bit OUT_W on a left shift
// Assumes OUT_W >= MAN so a right-shifted significand always fits in mag.
// -----------------------------------------------------------------------------
module f2i_shift #(
    parameter int MAN   = 23,
    parameter int OUT_W = 24,
    parameter int SH_W  = 16
) (
    input  logic [MAN:0]             mant,
    input  logic signed [SH_W-1:0]   shift,
    output logic [OUT_W:0]           mag,
    output logic                     guard,
    output logic                     sticky,
    output logic                     ovf
);
    localparam int LW = MAN + 1 + OUT_W;   // wide enough to see any overflow bit
    localparam int RW = 2 * MAN + 3;       // significand + guard + sticky field

    logic [LW-1:0] lwide;
    logic [RW-1:0] rwide;
    int            amt;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else can leave a value held and infer a latch.
    always_comb begin
        mag    = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        ovf    = 1'b0;
        lwide  = '0;
        rwide  = '0;
        amt    = int'(shift);
        if (amt >= 0) begin
            // The hidden one sits at bit MAN, so any shift past OUT_W overflows.
            if (amt > OUT_W) begin
                ovf = 1'b1;
            end else begin
                lwide = LW'(mant) << amt;
                mag   = lwide[OUT_W:0];
                ovf   = |lwide[LW-1:OUT_W+1];
            end
        end else if (-amt > MAN + 2) begin
            // Everything, including the guard position, fell off the bottom.
            sticky = 1'b1;
        end else begin
            rwide  = {mant, {(MAN+2){1'b0}}} >> (-amt);
            mag    = (OUT_W+1)'(rwide[RW-1:MAN+2]);
            guard  = rwide[MAN+1];
            sticky = |rwide[MAN:0];
        end
    end
endmodule

// File: rtl/float2int_pipe.sv
// -----------------------------------------------------------------------------
// float2int_pipe
// Three-stage float -> signed fixed-point converter with valid/ready
// backpressure; turns the float IIR stage's y_float back into integer samples.
//   S1 unpack : classify, restore hidden one, compute shift amount
//   S2 shift  : barrel shift to integer position (guard/sticky/overflow)
//   S3 finish : round, apply sign, saturate, handle Inf/NaN
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (drops all in-flight data)
//   io     float2int_pipe_if.slave: in_* float stream, out_* integer stream
// Build option: define F2I_ROUND_EN for round-half-to-even on the magnitude;
// otherwise the magnitude is truncated (toward zero). Timing is identical.
// -----------------------------------------------------------------------------
module float2int_pipe
    import f2i_pkg::*;
#(
    parameter int MAN   = 23,
    parameter int EXP   = 8,
    parameter int OUT_W = 24,
    parameter int FRAC  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    float2int_pipe_if.slave   io
);
    localparam int SH_W = 16;
    localparam int BIAS = exp_bias(EXP);

    // Magnitude limits (OUT_W+2 bits to hold a rounding carry) and output bounds.
    localparam logic [OUT_W+1:0] POS_LIM = {3'b000, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W+1:0] NEG_LIM = {3'b001, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] MAX_INT = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_INT = {1'b1, {(OUT_W-1){1'b0}}};

    typedef struct packed {
        f2i_meta_t               meta;
        logic [MAN:0]            mant;
        logic signed [SH_W-1:0]  shift;
    } s1_t;

    typedef struct packed {
        f2i_meta_t      meta;
        logic [OUT_W:0] mag;
        logic           guard;
        logic           sticky;
        logic           ovf;
    } s2_t;

    logic v1, v2, v3;
    logic rdy1, rdy2, rdy3;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;

    // ---------------- handshake ----------------
    // A stage may load when it is empty or its contents move on this cycle.
    assign rdy3         = ~v3 | io.out_ready;
    assign rdy2         = ~v2 | rdy3;
    assign rdy1         = ~v1 | rdy2;
    assign io.in_ready  = rdy1;
    assign io.out_valid = v3;

    // ---------------- S1: unpack ----------------
    logic           in_sign;
    logic [EXP-1:0] in_exp;
    logic [MAN-1:0] in_man;

    assign in_sign = f_sign(64'(io.in_float), MAN, EXP);
    assign in_exp  = EXP'(f_exp(64'(io.in_float), MAN, EXP));
    assign in_man  = MAN'(f_man(64'(io.in_float), MAN));

    always_comb begin
        s1_d.meta.sign = in_sign;
        s1_d.meta.cls  = classify(~|in_exp, &in_exp, ~|in_man);
        s1_d.mant      = {1'b1, in_man};
        s1_d.shift     = SH_W'(int'(in_exp) - BIAS - MAN + FRAC);
    end

    // ---------------- S2: shift ----------------
    logic [OUT_W:0] sh_mag;
    logic           sh_guard, sh_sticky, sh_ovf;

    f2i_shift #(
        .MAN   (MAN),
        .OUT_W (OUT_W),
        .SH_W  (SH_W)
    ) u_shift (
        .mant   (s1_q.mant),
        .shift  (s1_q.shift),
        .mag    (sh_mag),
        .guard  (sh_guard),
        .sticky (sh_sticky),
        .ovf    (sh_ovf)
    );

    always_comb begin
        s2_d.meta   = s1_q.meta;
        s2_d.mag    = sh_mag;
        s2_d.guard  = sh_guard;
        s2_d.sticky = sh_sticky;
        s2_d.ovf    = sh_ovf;
    end

    // ---------------- S3: round / sign / saturate ----------------
    logic             rnd_inc;
    logic [OUT_W+1:0] mag_r;
    logic [OUT_W+1:0] lim;
    logic [OUT_W-1:0] bound;
    logic [OUT_W-1:0] s3_int;
    logic             s3_sat, s3_nan;

`ifdef F2I_ROUND_EN
    // Round half to even: up when above half, or exactly half with odd LSB.
    assign rnd_inc = s2_q.guard & (s2_q.sticky | s2_q.mag[0]);
`else
    logic round_bits_unused;
    assign rnd_inc           = 1'b0;
    assign round_bits_unused = s2_q.guard ^ s2_q.sticky;
`endif

    always_comb begin
        mag_r  = {1'b0, s2_q.mag} + {{(OUT_W+1){1'b0}}, rnd_inc};
        // Negative side reaches one further: -2^(OUT_W-1) is representable.
        lim    = s2_q.meta.sign ? NEG_LIM : POS_LIM;
        bound  = s2_q.meta.sign ? MIN_INT : MAX_INT;
        s3_int = '0;
        s3_sat = 1'b0;
        s3_nan = 1'b0;
        case (s2_q.meta.cls)
            F2I_NAN: s3_nan = 1'b1;
            F2I_INF: begin
                s3_int = bound;
                s3_sat = 1'b1;
            end
            F2I_NORM: begin
                if (s2_q.ovf || (mag_r > lim)) begin
                    s3_int = bound;
                    s3_sat = 1'b1;
                end else begin
                    s3_int = s2_q.meta.sign ? -mag_r[OUT_W-1:0] : mag_r[OUT_W-1:0];
                end
            end
            default: ;  // F2I_ZERO: zero, no flags
        endcase
    end

    // ---------------- pipeline registers ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, whatever order the simulator runs the blocks in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (rdy1) v1 <= io.in_valid;
            if (rdy2) v2 <= v1;
            if (rdy3) v3 <= v2;
        end
    end

    // NOTE: payload registers are deliberately not reset; the valid bits alone
    // decide whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (rdy1) s1_q <= s1_d;
        if (rdy2) s2_q <= s2_d;
    end

    // Output registers are reset and only load real data, so they read zero
    // after reset and never show bubble contents.
    logic [OUT_W-1:0] out_int_q;
    logic             out_sat_q, out_nan_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_int_q <= '0;
            out_sat_q <= 1'b0;
            out_nan_q <= 1'b0;
        end else if (rdy3 && v2) begin
            out_int_q <= s3_int;
            out_sat_q <= s3_sat;
            out_nan_q <= s3_nan;
        end
    end

    assign io.out_int = out_int_q;
    assign io.out_sat = out_sat_q;
    assign io.out_nan = out_nan_q;

endmodule

// File: tb/tb_float2int_pipe.sv
// -----------------------------------------------------------------------------
// tb_float2int_pipe
// Directed self-checking bench for float2int_pipe (MAN=23, EXP=8, OUT_W=24,
// FRAC=0). Expected values are hand-computed; the rounding build is selected
// with F2I_ROUND_EN exactly as for the RTL.
// -----------------------------------------------------------------------------
module tb_float2int_pipe;

`ifdef F2I_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    typedef struct {
        logic [31:0] f;
        logic [23:0] i;
        logic        sat;
        logic        nan;
        string       name;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    float2int_pipe_if #(.MAN(23), .EXP(8), .OUT_W(24)) io ();

    float2int_pipe #(
        .MAN   (23),
        .EXP   (8),
        .OUT_W (24),
        .FRAC  (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    // Push one float into an idle pipe and wait (bounded) for its result.
    // lat counts clock edges from the accepting edge to out_valid; -1 = timeout.
    task automatic convert(input logic [31:0] f, output logic [23:0] r,
                           output logic sat, output logic nan, output int lat);
        lat = -1;
        r   = '0;
        sat = 1'b0;
        nan = 1'b0;
        @(negedge clk);
        io.in_valid = 1'b1;
        io.in_float = f;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            io.in_valid = 1'b0;
            if (io.out_valid) begin
                lat = n;
                r   = io.out_int;
                sat = io.out_sat;
                nan = io.out_nan;
                break;
            end
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if (io.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", io.out_valid);
        end
        n_checks++;
        if (io.out_int !== 24'd0) begin
            n_fail++; $display("FAIL reset_out_int: got %h want 000000", io.out_int);
        end
        n_checks++;
        if ({io.out_sat, io.out_nan} !== 2'b00) begin
            n_fail++; $display("FAIL reset_flags: got sat=%b nan=%b want 0 0", io.out_sat, io.out_nan);
        end
        n_checks++;
        if (io.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", io.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        vec_t        v[2];
        logic [23:0] r;
        logic        sat, nan;
        int          lat;
        v[0] = '{32'h3F800000, 24'd1,      1'b0, 1'b0, "one"};
        v[1] = '{32'hC2F60000, 24'hFFFF85, 1'b0, 1'b0, "minus_123"};
        foreach (v[k]) begin
            convert(v[k].f, r, sat, nan, lat);
            n_checks++;
            if (lat !== 3) begin
                n_fail++; $display("FAIL %s_latency: got %0d want 3", v[k].name, lat);
            end
            n_checks++;
            if (r !== v[k].i) begin
                n_fail++; $display("FAIL %s_int: got %0d want %0d", v[k].name, $signed(r), $signed(v[k].i));
            end
            n_checks++;
            if ({sat, nan} !== {v[k].sat, v[k].nan}) begin
                n_fail++; $display("FAIL %s_flags: got sat=%b nan=%b want sat=%b nan=%b",
                                   v[k].name, sat, nan, v[k].sat, v[k].nan);
            end
        end
    endtask

    task automatic test_rounding;
        vec_t        v[7];
        logic [23:0] r;
        logic        sat, nan;
        int          lat;
        v[0] = '{32'h40200000, 24'd2,                          1'b0, 1'b0, "p2_5"};
        v[1] = '{32'h40600000, RND ? 24'd4 : 24'd3,            1'b0, 1'b0, "p3_5"};
        v[2] = '{32'hC0200000, 24'hFFFFFE,                     1'b0, 1'b0, "m2_5"};
        v[3] = '{32'hC0600000, RND ? 24'hFFFFFC : 24'hFFFFFD,  1'b0, 1'b0, "m3_5"};
        v[4] = '{32'h3FC00000, RND ? 24'd2 : 24'd1,            1'b0, 1'b0, "p1_5"};
        v[5] = '{32'h3F000000, 24'd0,                          1'b0, 1'b0, "p0_5"};
        v[6] = '{32'h40300000, RND ? 24'd3 : 24'd2,            1'b0, 1'b0, "p2_75"};
        foreach (v[k]) begin
            convert(v[k].f, r, sat, nan, lat);
            n_checks++;
            if (r !== v[k].i || lat !== 3) begin
                n_fail++; $display("FAIL %s: got %0d lat=%0d want %0d lat=3",
                                   v[k].name, $signed(r), lat, $signed(v[k].i));
            end
            n_checks++;
            if ({sat, nan} !== 2'b00) begin
                n_fail++; $display("FAIL %s_flags: got sat=%b nan=%b want 0 0", v[k].name, sat, nan);
            end
        end
    endtask

    task automatic test_saturation;
        vec_t        v[7];
        logic [23:0] r;
        logic        sat, nan;
        int          lat;
        v[0] = '{32'h4B800000, 24'h7FFFFF, 1'b1, 1'b0, "p2pow24"};
        v[1] = '{32'hCB000000, 24'h800000, 1'b0, 1'b0, "m2pow23"};
        v[2] = '{32'hFF800000, 24'h800000, 1'b1, 1'b0, "minus_inf"};
        v[3] = '{32'h7F800000, 24'h7FFFFF, 1'b1, 1'b0, "plus_inf"};
        v[4] = '{32'h4AFFFFFE, 24'h7FFFFF, 1'b0, 1'b0, "max_exact"};
        v[5] = '{32'hCB000001, 24'h800000, 1'b1, 1'b0, "below_min"};
        v[6] = '{32'h7F000000, 24'h7FFFFF, 1'b1, 1'b0, "p2pow127"};
        foreach (v[k]) begin
            convert(v[k].f, r, sat, nan, lat);
            n_checks++;
            if (r !== v[k].i || lat !== 3) begin
                n_fail++; $display("FAIL %s: got %h lat=%0d want %h lat=3", v[k].name, r, lat, v[k].i);
            end
            n_checks++;
            if ({sat, nan} !== {v[k].sat, v[k].nan}) begin
                n_fail++; $display("FAIL %s_flags: got sat=%b nan=%b want sat=%b nan=%b",
                                   v[k].name, sat, nan, v[k].sat, v[k].nan);
            end
        end
    endtask

    task automatic test_special;
        vec_t        v[5];
        logic [23:0] r;
        logic        sat, nan;
        int          lat;
        v[0] = '{32'h7FC00000, 24'd0, 1'b0, 1'b1, "qnan"};
        v[1] = '{32'hFFC00000, 24'd0, 1'b0, 1'b1, "neg_nan"};
        v[2] = '{32'h7F800001, 24'd0, 1'b0, 1'b1, "snan"};
        v[3] = '{32'h80000000, 24'd0, 1'b0, 1'b0, "neg_zero"};
        v[4] = '{32'h00000001, 24'd0, 1'b0, 1'b0, "denormal"};
        foreach (v[k]) begin
            convert(v[k].f, r, sat, nan, lat);
            n_checks++;
            if (r !== v[k].i || lat !== 3) begin
                n_fail++; $display("FAIL %s: got %h lat=%0d want %h lat=3", v[k].name, r, lat, v[k].i);
            end
            n_checks++;
            if ({sat, nan} !== {v[k].sat, v[k].nan}) begin
                n_fail++; $display("FAIL %s_flags: got sat=%b nan=%b want sat=%b nan=%b",
                                   v[k].name, sat, nan, v[k].sat, v[k].nan);
            end
        end
    endtask

    // Six inputs offered back to back; the sink stalls in cycles 2..7.
    task automatic test_back_to_back;
        logic [31:0] vin[6];
        logic [23:0] got[$];
        logic [23:0] held;
        logic        held_v;
        int          idx, first_drop;
        vin[0] = 32'h3F800000;  // 1.0
        vin[1] = 32'h40000000;  // 2.0
        vin[2] = 32'h40400000;  // 3.0
        vin[3] = 32'h40800000;  // 4.0
        vin[4] = 32'h40A00000;  // 5.0
        vin[5] = 32'h40C00000;  // 6.0
        idx        = 0;
        first_drop = -1;
        held       = '0;
        held_v     = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            io.out_ready = !(c >= 2 && c <= 7);
            io.in_valid  = (idx < 6);
            io.in_float  = (idx < 6) ? vin[idx] : 32'h0;
            #1;
            if (!io.in_ready && first_drop < 0) first_drop = idx;
            if (io.in_valid && io.in_ready) idx++;
            if (io.out_valid && !io.out_ready) begin
                if (held_v) begin
                    n_checks++;
                    if (io.out_int !== held) begin
                        n_fail++; $display("FAIL b2b_stall_stable: got %0d want %0d", io.out_int, held);
                    end
                end
                held_v = 1'b1;
                held   = io.out_int;
            end else begin
                held_v = 1'b0;
            end
            if (io.out_valid && io.out_ready) got.push_back(io.out_int);
        end
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        n_checks++;
        if (first_drop !== 3) begin
            n_fail++; $display("FAIL b2b_in_ready_drop: accepted %0d before drop want 3", first_drop);
        end
        n_checks++;
        if (got.size() !== 6) begin
            n_fail++; $display("FAIL b2b_count: got %0d outputs want 6", got.size());
        end
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (k >= got.size() || got[k] !== 24'(k + 1)) begin
                n_fail++; $display("FAIL b2b_order_%0d: got %0d want %0d", k,
                                   (k < got.size()) ? got[k] : 24'hFFFFFF, k + 1);
            end
        end
    endtask

    // Reset with three items in flight, output held by a stalled sink.
    task automatic test_reset_in_flight;
        logic [31:0] vin[3];
        int          seen;
        vin[0] = 32'h40E00000;  // 7.0
        vin[1] = 32'h41000000;  // 8.0
        vin[2] = 32'h41100000;  // 9.0
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            io.out_ready = 1'b1;
            io.in_valid  = 1'b1;
            io.in_float  = vin[k];
        end
        @(negedge clk);
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        #1;
        n_checks++;
        if (io.out_valid !== 1'b1 || io.out_int !== 24'd7) begin
            n_fail++; $display("FAIL rif_pre_reset: got valid=%b int=%0d want valid=1 int=7",
                               io.out_valid, io.out_int);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (io.out_valid !== 1'b0 || io.out_int !== 24'd0) begin
            n_fail++; $display("FAIL rif_async_clear: got valid=%b int=%0d want valid=0 int=0",
                               io.out_valid, io.out_int);
        end
        n_checks++;
        if ({io.out_sat, io.out_nan, io.in_ready} !== 3'b001) begin
            n_fail++; $display("FAIL rif_flags: got sat=%b nan=%b in_ready=%b want 0 0 1",
                               io.out_sat, io.out_nan, io.in_ready);
        end
        @(negedge clk);
        rst_n        = 1'b1;
        io.out_ready = 1'b1;
        seen         = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (io.out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL rif_no_stale: got %0d valid cycles want 0", seen);
        end
    endtask

    initial begin
        io.in_valid  = 1'b0;
        io.in_float  = 32'h0;
        io.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        test_basic;
        test_rounding;
        test_saturation;
        test_special;
        test_back_to_back;
        test_reset_in_flight;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
